// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: opcode/branch codes, FSM states and combinational ALU helpers shared by alu_exec.
package alu_exec_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1101;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    function automatic logic is_shift_op(input logic [3:0] op, input logic br);
        return !br && (op == OP_SLL || op == OP_SRL || op == OP_SRA);
    endfunction

    function automatic logic [31:0] alu_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_SUB:  return a - b;
            OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
            OP_SLTU: return {31'd0, a < b};
            OP_XOR:  return a ^ b;
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            default: return a + b;
        endcase
    endfunction

    function automatic logic br_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            BR_EQ:   return a == b;
            BR_NE:   return a != b;
            BR_LT:   return $signed(a) < $signed(b);
            BR_GE:   return $signed(a) >= $signed(b);
            BR_LTU:  return a < b;
            BR_GEU:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: serial one-bit-per-cycle shifter; done flags the cycle whose edge performs the final step.
module alu_shifter (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] data_in,
    input  logic [4:0]  shamt,
    input  logic        left,
    input  logic        arith,
    output logic [31:0] data,
    output logic        done
);
    logic [4:0] cnt;
    logic       left_q;
    logic       arith_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            data    <= '0;
            cnt     <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else if (start) begin
            data    <= data_in;
            cnt     <= shamt;
            left_q  <= left;
            arith_q <= arith;
        end else if (cnt != 5'd0) begin
            data <= left_q ? {data[30:0], 1'b0} : {arith_q & data[31], data[31:1]};
            cnt  <= cnt - 5'd1;
        end
    end

    assign done = cnt == 5'd1;
endmodule

// File: rtl/alu_exec.sv
// alu_exec: single-issue ALU/branch execute stage with valid/ready handshakes and a serial shifter.
module alu_exec
    import alu_exec_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  alu_op,
    input  logic        is_branch,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        br_taken,
    output logic [31:0] br_target
);
    state_t      state;
    state_t      state_n;
    logic [3:0]  op_q;
    logic        br_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] pc_q;
    logic [31:0] imm_q;
    logic [31:0] sh_data;
    logic        sh_done;
    logic        accept;
    logic        sh_start;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign accept    = in_valid && in_ready;
    assign sh_start  = accept && is_shift_op(alu_op, is_branch);

    alu_shifter u_shifter (
        .clock   (clock),
        .reset   (reset),
        .start   (sh_start),
        .data_in (op_a),
        .shamt   (op_b[4:0]),
        .left    (alu_op == OP_SLL),
        .arith   (alu_op == OP_SRA),
        .data    (sh_data),
        .done    (sh_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            op_q  <= '0;
            br_q  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            pc_q  <= '0;
            imm_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_q  <= alu_op;
                br_q  <= is_branch;
                a_q   <= op_a;
                b_q   <= op_b;
                pc_q  <= pc;
                imm_q <= imm;
            end
        end
    end

    // A zero shift amount skips SHIFT: the shifter already holds op_a unchanged.
    always_comb begin
        state_n = state == IDLE  ? (accept ? ((sh_start && op_b[4:0] != 5'd0) ? SHIFT : DONE) : IDLE) :
                  state == SHIFT ? (sh_done ? DONE : SHIFT) :
                                   (out_ready ? IDLE : DONE);
    end

    // Outputs derive only from captured operands, so they hold steady in DONE.
    assign result    = br_q ? '0 : is_shift_op(op_q, br_q) ? sh_data : alu_calc(op_q, a_q, b_q);
    assign br_taken  = br_q && br_cond(op_q[2:0], a_q, b_q);
    assign br_target = pc_q + imm_q;
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed self-checking bench for alu_exec with hand-computed expectations.
module tb_alu_exec;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_op = 4'd0;
    logic        is_branch = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [31:0] pc = '0;
    logic [31:0] imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        br_taken;
    logic [31:0] br_target;

    int tests = 0;
    int failed = 0;
    int lat;
    int stale;

    alu_exec dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .is_branch (is_branch),
        .op_a      (op_a),
        .op_b      (op_b),
        .pc        (pc),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .br_taken  (br_taken),
        .br_target (br_target)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic br, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] i);
        @(negedge clock);
        alu_op = op; is_branch = br; op_a = a; op_b = b; pc = p; imm = i; in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        op_a = 32'hDEADBEEF; op_b = 32'h0000001F; pc = 32'h5555AAAA; imm = 32'h12345678; alu_op = 4'b1000;
    endtask

    task automatic wait_valid(output int l);
        l = 1;
        while (!out_valid && l < 64) begin
            @(posedge clock);
            #1;
            l++;
        end
    endtask

    task automatic op_check(input string tag, input logic [3:0] op, input logic br, input logic [31:0] a,
                            input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res, input logic exp_bt);
        int l;
        send(op, br, a, b, 32'h1000, 32'h4);
        wait_valid(l);
        chk({tag, "_lat"}, l, exp_lat);
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_bt"}, {31'd0, br_taken}, {31'd0, exp_bt});
        chk({tag, "_tgt"}, br_target, 32'h1004);
        @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_br_taken", {31'd0, br_taken}, 32'd0);
        chk("rst_br_target", br_target, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        op_check("add_wrap", 4'b0000, 1'b0, 32'hFFFFFFFF, 32'h1, 1, 32'h0, 1'b0);
        chk("add_back_idle", {30'd0, in_ready, out_valid}, 32'b10);
        op_check("sra4", 4'b1101, 1'b0, 32'h80000000, 32'h4, 5, 32'hF8000000, 1'b0);
        op_check("sra0", 4'b1101, 1'b0, 32'h80000000, 32'h0, 1, 32'h80000000, 1'b0);
        op_check("sll3", 4'b0001, 1'b0, 32'h00000003, 32'h23, 4, 32'h00000018, 1'b0);
        op_check("srl1", 4'b0101, 1'b0, 32'h80000000, 32'h1, 2, 32'h40000000, 1'b0);
        op_check("sub", 4'b1000, 1'b0, 32'h5, 32'h7, 1, 32'hFFFFFFFE, 1'b0);
        op_check("xor", 4'b0100, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 1, 32'hFF00FF00, 1'b0);
        op_check("or", 4'b0110, 1'b0, 32'h0F000000, 32'h00F00001, 1, 32'h0FF00001, 1'b0);
        op_check("and", 4'b0111, 1'b0, 32'hFFFF0000, 32'h12345678, 1, 32'h12340000, 1'b0);
        op_check("sltu", 4'b0011, 1'b0, 32'h1, 32'hFFFFFFFF, 1, 32'h1, 1'b0);
        op_check("slt_neg", 4'b0010, 1'b0, 32'h1, 32'hFFFFFFFF, 1, 32'h0, 1'b0);
        op_check("op1010_add", 4'b1010, 1'b0, 32'h2, 32'h3, 1, 32'h5, 1'b0);
        op_check("beq_ne", 4'b0000, 1'b1, 32'h5, 32'h6, 1, 32'h0, 1'b0);
        op_check("bne", 4'b0001, 1'b1, 32'h5, 32'h6, 1, 32'h0, 1'b1);
        op_check("bge_eq", 4'b1101, 1'b1, 32'h5, 32'h5, 1, 32'h0, 1'b1);
        op_check("br010", 4'b0010, 1'b1, 32'h5, 32'h5, 1, 32'h0, 1'b0);
        op_check("bgeu", 4'b1111, 1'b1, 32'h1, 32'hFFFFFFFF, 1, 32'h0, 1'b0);

        send(4'b1100, 1'b1, 32'hFFFFFFFF, 32'h1, 32'h100, 32'hFFFFFFF8);
        wait_valid(lat);
        chk("blt_lat", lat, 1);
        chk("blt_taken", {31'd0, br_taken}, 32'd1);
        chk("blt_target", br_target, 32'h000000F8);
        chk("blt_result", result, 32'd0);
        @(posedge clock);
        #1;
        send(4'b1110, 1'b1, 32'hFFFFFFFF, 32'h1, 32'h100, 32'hFFFFFFF8);
        wait_valid(lat);
        chk("bltu_taken", {31'd0, br_taken}, 32'd0);
        chk("bltu_target", br_target, 32'h000000F8);
        @(posedge clock);
        #1;

        out_ready = 1'b0;
        send(4'b0010, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h10);
        wait_valid(lat);
        chk("slt_lat", lat, 1);
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk("slt_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("slt_hold_result", result, 32'd1);
            chk("slt_hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("slt_hold_target", br_target, 32'h210);
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("slt_pre_hs_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clock);
        #1;
        chk("slt_post_hs_in_ready", {31'd0, in_ready}, 32'd1);
        chk("slt_post_hs_valid", {31'd0, out_valid}, 32'd0);

        send(4'b0001, 1'b0, 32'h00000001, 32'd31, 32'h300, 32'h8);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("sll_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("sll_rst_result", result, 32'd0);
        chk("sll_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("sll_rst_target", br_target, 32'd0);
        stale = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (out_valid) stale++;
        end
        chk("sll_rst_no_stale", stale, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have the following ports, in order:
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  block can accept an operation.
- alu_op  input  4  {inst[30], funct3} code from the decode stage.
- is_branch  input  1  operation is a conditional branch; alu_op[2:0] is then the branch funct3.
- op_a  input  32  rs1 value.
- op_b  input  32  rs2 value or immediate.
- pc  input  32  instruction address.
- imm  input  32  sign-extended branch offset.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- result  output  32  ALU result.
- br_taken  output  1  branch condition true.
- br_target  output  32  pc + imm.

REQ-002 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-003 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-004 SHALL drive in_ready high only in IDLE.
REQ-005 SHALL accept an operation on a rising edge with in_valid && in_ready, registering alu_op, is_branch, op_a, op_b, pc and imm.
REQ-006 Non-shift ops: SHALL go IDLE->DONE and assert out_valid the cycle after acceptance (latency 1).
REQ-007 Shifts are non-branch alu_op 0001 SLL, 0101 SRL and 1101 SRA, with shamt = op_b[4:0].
- shamt 0: SHALL go directly to DONE with result = op_a.
- Otherwise: SHALL enter SHIFT, shift one bit per cycle, and enter DONE after shamt cycles (out_valid latency 1+shamt).
REQ-008 Non-branch codes SHALL compute:
- 0000 ADD: a+b; 1000 SUB: a-b.
- 0010 SLT: signed compare; 0011 SLTU: unsigned compare, both zero-extended to 32 bits.
- 0100 XOR; 0110 OR; 0111 AND.
- All other codes: a+b.
- All arithmetic is mod 2^32, with no overflow flag.
REQ-009 Branch ops SHALL set br_taken from alu_op[2:0]:
- 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
- 010 and 011: not taken.
- result = 0.
REQ-010 Non-branch ops SHALL set br_taken to 0.
REQ-011 SHALL compute br_target = pc + imm (mod 2^32) for every op.
REQ-012 In DONE, out_valid SHALL be 1 and result/br_taken/br_target SHALL stay stable until out_valid && out_ready.
REQ-013 On that handshake SHALL go to IDLE; the next op can be accepted one cycle later.
REQ-014 in_valid SHALL be ignored outside IDLE; input changes after acceptance SHALL NOT affect the in-flight op.
REQ-015 SRA SHALL replicate op_a[31] on every step; SRL/SLL SHALL shift in zeros.

Reset
REQ-016 With reset high at a rising edge, SHALL go to IDLE and drive out_valid=0, result=0, br_taken=0, br_target=0 and shift counter=0.
REQ-017 Reset SHALL take priority over every handshake; an in-flight op (SHIFT or DONE) SHALL be discarded and not presented afterward.
REQ-018 in_ready SHALL be 1 on the first cycle after reset deasserts.

Structure
REQ-019 alu_op codes (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND) and branch funct3 values SHALL live in the shared codes include; no literal opcodes in the module.
REQ-020 The serial shifter (data register, 5-bit down-counter, direction/arith control, done flag) SHALL be a sub-module named alu_shifter.

Verification
REQ-021 ADD a=0xFFFFFFFF, b=1, out_ready=1 -> out_valid 1 cycle after accept, result=0x00000000, br_taken=0.
REQ-022 SRA a=0x80000000, b=4 -> out_valid 5 cycles after accept, result=0xF8000000; same with b=0 -> 1 cycle, result=0x80000000.
REQ-023 Branch alu_op=1100 (BLT), a=0xFFFFFFFF, b=1, pc=0x100, imm=0xFFFFFFF8 -> br_taken=1, br_target=0x000000F8; same with 1110 (BLTU) -> br_taken=0.
REQ-024 SLT with out_ready held 0 for 3 cycles -> out_valid and result stable throughout, in_ready=0; accept occurs 1 cycle after out_ready rises.
REQ-025 SLL b=31 with reset asserted in the 3rd SHIFT cycle -> next cycle out_valid=0, result=0, in_ready=1; no stale output.
